// File: rtl/tl_a_arbiter.sv
// Round-robin arbiter for TileLink channel A: NUM_REQ clients share one manager port, whole messages at a time.
// Define TL_ARB_STATS_EN to add per-client message counters on stat_msgs.
module tl_a_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int SOURCE_W = 4,
    parameter int NUM_REQ  = 2,
    parameter int MAX_SIZE = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           s_a_valid,
    output logic [NUM_REQ-1:0]           s_a_ready,
    input  logic [3*NUM_REQ-1:0]         s_a_opcode,
    input  logic [3*NUM_REQ-1:0]         s_a_param,
    input  logic [4*NUM_REQ-1:0]         s_a_size,
    input  logic [SOURCE_W*NUM_REQ-1:0]  s_a_source,
    input  logic [ADDR_W*NUM_REQ-1:0]    s_a_address,
    input  logic [8*NUM_REQ-1:0]         s_a_mask,
    input  logic [DATA_W*NUM_REQ-1:0]    s_a_data,
    output logic                         m_a_valid,
    input  logic                         m_a_ready,
    output logic [2:0]                   m_a_opcode,
    output logic [2:0]                   m_a_param,
    output logic [3:0]                   m_a_size,
    output logic [SOURCE_W-1:0]          m_a_source,
    output logic [ADDR_W-1:0]            m_a_address,
    output logic [7:0]                   m_a_mask,
    output logic [DATA_W-1:0]            m_a_data,
`ifdef TL_ARB_STATS_EN
    output logic [32*NUM_REQ-1:0]        stat_msgs,
`endif
    output logic [2:0]                   m_a_owner
);

    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LOG_BYTES = $clog2(DATA_W / 8);
    localparam int SPAN      = (MAX_SIZE > LOG_BYTES) ? MAX_SIZE - LOG_BYTES : 0;
    localparam int CNT_W     = SPAN + 1;

    typedef enum logic [1:0] {IDLE, HOLD, BURST} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, owner, rr_sel, sel;
    logic [CNT_W-1:0] beats_left, beats;
    logic [3:0]       eff_size;
    logic             fire, last;
    int               cand;

    // Scan from the highest offset down so the lowest offset past rr_ptr wins.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        rr_sel = rr_ptr;
        cand   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (s_a_valid[cand]) rr_sel = IDX_W'(cand);
        end
    end

    assign sel = (state == IDLE) ? rr_sel : owner;

    assign m_a_opcode  = s_a_opcode[3*sel +: 3];
    assign m_a_param   = s_a_param[3*sel +: 3];
    assign m_a_size    = s_a_size[4*sel +: 4];
    assign m_a_source  = s_a_source[SOURCE_W*sel +: SOURCE_W];
    assign m_a_address = s_a_address[ADDR_W*sel +: ADDR_W];
    assign m_a_mask    = s_a_mask[8*sel +: 8];
    assign m_a_data    = s_a_data[DATA_W*sel +: DATA_W];
    assign m_a_owner   = 3'(sel);

    // Beats in the message whose first beat is currently presented.
    always_comb begin
        eff_size = (m_a_size > 4'(MAX_SIZE)) ? 4'(MAX_SIZE) : m_a_size;
        beats    = CNT_W'(1);
        if ((m_a_opcode == 3'd0 || m_a_opcode == 3'd1) && eff_size > 4'(LOG_BYTES))
            beats = CNT_W'(1) << (eff_size - 4'(LOG_BYTES));
    end

    assign fire = m_a_valid && m_a_ready;
    assign last = (state == BURST) ? (beats_left == CNT_W'(1)) : (beats == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, HOLD: begin
                if (fire)           state_nxt = last ? IDLE : BURST;
                else if (m_a_valid) state_nxt = HOLD;
            end
            BURST: if (fire && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are gated by rst so nothing handshakes while reset is held.
    always_comb begin
        m_a_valid = s_a_valid[sel] && !rst;
        s_a_ready = '0;
        if (m_a_ready && !rst) s_a_ready[sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            owner      <= '0;
            beats_left <= '0;
        end else begin
            if (state == IDLE && m_a_valid) owner <= sel;
            if (fire) begin
                beats_left <= (state == BURST) ? beats_left - CNT_W'(1) : beats - CNT_W'(1);
                if (last) rr_ptr <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

`ifdef TL_ARB_STATS_EN
    logic [31:0] stat_cnt [NUM_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
        end else if (fire && last) begin
            stat_cnt[sel] <= stat_cnt[sel] + 32'd1;
        end
    end

    always_comb begin
        stat_msgs = '0;
        for (int i = 0; i < NUM_REQ; i++) stat_msgs[32*i +: 32] = stat_cnt[i];
    end
`endif

endmodule

// File: tb/tb_tl_a_arbiter.sv
// Randomized bench for tl_a_arbiter against a message-level round-robin model.
module tb_tl_a_arbiter;

    localparam int N  = 3;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = 4;
    localparam int MS = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      s_a_valid = '0;
    logic [N-1:0]      s_a_ready;
    logic [3*N-1:0]    s_a_opcode = '0, s_a_param = '0;
    logic [4*N-1:0]    s_a_size = '0;
    logic [SW*N-1:0]   s_a_source = '0;
    logic [AW*N-1:0]   s_a_address = '0;
    logic [8*N-1:0]    s_a_mask = '0;
    logic [DW*N-1:0]   s_a_data = '0;
    logic              m_a_valid, m_a_ready = 1'b0;
    logic [2:0]        m_a_opcode, m_a_param, m_a_owner;
    logic [3:0]        m_a_size;
    logic [SW-1:0]     m_a_source;
    logic [AW-1:0]     m_a_address;
    logic [7:0]        m_a_mask;
    logic [DW-1:0]     m_a_data;
`ifdef TL_ARB_STATS_EN
    logic [32*N-1:0]   stat_msgs;
`endif

    tl_a_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SOURCE_W(SW), .NUM_REQ(N), .MAX_SIZE(MS)) dut (
        .clk(clk), .rst(rst),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
        .s_a_opcode(s_a_opcode), .s_a_param(s_a_param), .s_a_size(s_a_size),
        .s_a_source(s_a_source), .s_a_address(s_a_address), .s_a_mask(s_a_mask),
        .s_a_data(s_a_data),
        .m_a_valid(m_a_valid), .m_a_ready(m_a_ready),
        .m_a_opcode(m_a_opcode), .m_a_param(m_a_param), .m_a_size(m_a_size),
        .m_a_source(m_a_source), .m_a_address(m_a_address), .m_a_mask(m_a_mask),
        .m_a_data(m_a_data),
`ifdef TL_ARB_STATS_EN
        .stat_msgs(stat_msgs),
`endif
        .m_a_owner(m_a_owner)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Client-side message state.
    logic [2:0]  c_op   [N];
    logic [2:0]  c_par  [N];
    logic [3:0]  c_size [N];
    logic [3:0]  c_src  [N];
    logic [63:0] c_addr [N];
    logic [63:0] c_data [N];
    logic [7:0]  c_mask [N];
    bit          c_valid[N];
    bit          c_started[N];
    int          c_total[N];
    int          c_left[N];

    // Reference model: pointer, locked owner (-1 = none), beats still owed after the first.
    int ref_ptr = 0;
    int ref_lock = -1;
    int ref_rem = 0;
    int ref_stats[N];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int msg_beats(input logic [2:0] op, input logic [3:0] size);
        int s;
        s = (int'(size) > MS) ? MS : int'(size);
        if (op > 3'd1 || s <= 3) return 1;
        return 1 << (s - 3);
    endfunction

    task automatic new_msg(input int i);
        case ($urandom % 8)
            0, 1:    c_op[i] = 3'd0;
            2, 3:    c_op[i] = 3'd1;
            4:       c_op[i] = 3'd2;
            5:       c_op[i] = 3'd3;
            default: c_op[i] = 3'd4;
        endcase
        c_size[i]    = ($urandom % 8 == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
        c_par[i]     = 3'($urandom);
        c_src[i]     = 4'($urandom);
        c_addr[i]    = {$urandom, $urandom};
        c_data[i]    = {$urandom, $urandom};
        c_mask[i]    = 8'($urandom);
        c_total[i]   = msg_beats(c_op[i], c_size[i]);
        c_left[i]    = c_total[i];
        c_started[i] = 1'b0;
        c_valid[i]   = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_a_valid[i]            = c_valid[i];
            s_a_opcode[3*i +: 3]    = c_op[i];
            s_a_param[3*i +: 3]     = c_par[i];
            s_a_size[4*i +: 4]      = c_size[i];
            s_a_source[SW*i +: SW]  = c_src[i];
            s_a_address[AW*i +: AW] = c_addr[i];
            s_a_mask[8*i +: 8]      = c_mask[i];
            s_a_data[DW*i +: DW]    = c_data[i];
        end
    endtask

    initial begin
        int  exp_own, last_rst, idx;
        bit  exp_v, force_all, fire;

        for (int i = 0; i < N; i++) begin
            new_msg(i);
            c_valid[i]   = 1'b1;
            ref_stats[i] = 0;
        end
        m_a_ready = 1'b1;
        drive();
        #3;
        check("reset_m_a_valid", 64'(m_a_valid), 64'd0);
        check("reset_s_a_ready", 64'(s_a_ready), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        force_all = 1'b1;
        last_rst  = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            // Pulse reset in the middle of a burst; clients restart their messages.
            if (ref_rem > 0 && cyc - last_rst > 600) begin
                last_rst = cyc;
                rst = 1'b1;
                for (int i = 0; i < N; i++) c_valid[i] = 1'b1;
                drive();
                #1;
                check("midrst_m_a_valid", 64'(m_a_valid), 64'd0);
                check("midrst_s_a_ready", 64'(s_a_ready), 64'd0);
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                ref_ptr = 0; ref_lock = -1; ref_rem = 0;
                for (int i = 0; i < N; i++) begin
                    ref_stats[i] = 0;
                    c_started[i] = 1'b0;
                    c_left[i]    = c_total[i];
                end
                force_all = 1'b1;
            end

            for (int i = 0; i < N; i++) begin
                if (force_all)                        c_valid[i] = 1'b1;
                else if (c_valid[i] && !c_started[i]) c_valid[i] = 1'b1;
                else if (c_started[i])                c_valid[i] = ($urandom % 4) != 0;
                else                                  c_valid[i] = ($urandom % 10) < 6;
            end
            force_all = 1'b0;
            m_a_ready = ($urandom % 4) != 0;
            drive();
            #1;

            exp_own = -1;
            if (ref_lock >= 0) begin
                exp_own = ref_lock;
                exp_v   = c_valid[exp_own];
            end else begin
                for (int k = 0; k < N; k++) begin
                    idx = (ref_ptr + k) % N;
                    if (c_valid[idx] && exp_own < 0) exp_own = idx;
                end
                exp_v = exp_own >= 0;
            end

            check("m_a_valid", 64'(m_a_valid), 64'(exp_v));
            if (exp_own >= 0)
                check("s_a_ready", 64'(s_a_ready), m_a_ready ? (64'd1 << exp_own) : 64'd0);
            if (exp_v) begin
                check("m_a_owner",   64'(m_a_owner),  64'(exp_own));
                check("m_a_opcode",  64'(m_a_opcode), 64'(c_op[exp_own]));
                check("m_a_param",   64'(m_a_param),  64'(c_par[exp_own]));
                check("m_a_size",    64'(m_a_size),   64'(c_size[exp_own]));
                check("m_a_source",  64'(m_a_source), 64'(c_src[exp_own]));
                check("m_a_address", m_a_address,     c_addr[exp_own]);
                check("m_a_mask",    64'(m_a_mask),   64'(c_mask[exp_own]));
                check("m_a_data",    m_a_data,        c_data[exp_own]);
            end

            @(posedge clk);
            fire = exp_v && m_a_ready;
            if (fire) begin
                if (ref_rem > 0) begin
                    ref_rem--;
                    if (ref_rem == 0) begin
                        ref_lock = -1;
                        ref_ptr  = (exp_own + 1) % N;
                        ref_stats[exp_own]++;
                    end
                end else if (c_total[exp_own] > 1) begin
                    ref_lock = exp_own;
                    ref_rem  = c_total[exp_own] - 1;
                end else begin
                    ref_lock = -1;
                    ref_ptr  = (exp_own + 1) % N;
                    ref_stats[exp_own]++;
                end
                c_started[exp_own] = 1'b1;
                c_left[exp_own]--;
                c_data[exp_own] = {$urandom, $urandom};
                c_mask[exp_own] = 8'($urandom);
                if (c_left[exp_own] == 0) new_msg(exp_own);
            end else if (exp_v && ref_lock < 0) begin
                ref_lock = exp_own;
            end
            @(negedge clk);
        end

`ifdef TL_ARB_STATS_EN
        for (int i = 0; i < N; i++)
            check("stat_msgs", 64'(stat_msgs[32*i +: 32]), 64'(ref_stats[i]));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
